// File: rtl/bcd_serial_deserializer_pkg.sv
// bcd_pkg: shared constants for the serial BCD deserializer slice.
//   DIGIT_W        width of one BCD digit
//   BCD_MAX        largest legal BCD code
//   BITS_PER_DIGIT serial bits that make up one digit
package bcd_pkg;
  localparam int          DIGIT_W        = 4;
  localparam logic [3:0]  BCD_MAX        = 4'd9;
  localparam int          BITS_PER_DIGIT = 4;
endpackage

// File: rtl/bcd_serial_deserializer_fifo.sv
// bcd_digit_fifo: small digit FIFO with a registered head output.
//   Clk, Rst   clock, async active-low reset
//   push/din   write request and digit
//   pop/dout   read request and registered head digit (holds when empty)
//   full/empty occupancy flags
//   count      occupancy 0..DEPTH
// A push while full is accepted only if a pop happens in the same cycle.
module bcd_digit_fifo
  import bcd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               push,
  input  logic [DIGIT_W-1:0] din,
  input  logic               pop,
  output logic [DIGIT_W-1:0] dout,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        count
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DIGIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr, rd_nxt;
  logic               wr_ok, rd_ok;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign rd_ok  = pop && !empty;
  assign wr_ok  = push && (!full || rd_ok);
  assign rd_nxt = rd_ptr + AW'(1);

  always_ff @(posedge Clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_nxt;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
      // Head register tracks the entry that will sit at rd_ptr after this edge.
      // When full with push+pop, wr_ptr==rd_ptr, so the next head comes from
      // rd_nxt and is never the slot being overwritten.
      if (rd_ok) begin
        if (count > (AW+1)'(1)) dout <= mem[rd_nxt];
        else if (wr_ok)         dout <= din;
      end else if (wr_ok && empty) begin
        dout <= din;
      end
    end
  end
endmodule

// File: rtl/bcd_serial_deserializer.sv
// bcd_serial_deserializer: reassembles LSB-first serial BCD digits, drops
// non-BCD nibbles, queues good digits and drains them over valid/ready.
//   Clk, Rst     clock, async active-low reset
//   Din, Din_en  serial bit and its qualifier
//   Sync         restart digit assembly (partial nibble discarded)
//   Digit        FIFO head digit; Digit_valid = FIFO non-empty
//   Digit_ready  consumer accept
//   Bad_digit    one-cycle pulse after a nibble >9 is dropped
//   Ovf          sticky: good digit lost to a full FIFO
//   Count        FIFO occupancy
module bcd_serial_deserializer
  import bcd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Din,
  input  logic               Din_en,
  input  logic               Sync,
  output logic [DIGIT_W-1:0] Digit,
  output logic               Digit_valid,
  input  logic               Digit_ready,
  output logic               Bad_digit,
  output logic               Ovf,
  output logic [AW:0]        Count
);
  logic [1:0]         bit_cnt, cnt_eff;
  logic [2:0]         sr, sr_eff, sr_nxt;
  logic [DIGIT_W-1:0] nibble;
  logic               complete, good, bad, pop, full, empty;

  // Sync acts as if assembly state were already cleared this cycle.
  assign cnt_eff  = Sync ? 2'd0 : bit_cnt;
  assign sr_eff   = Sync ? 3'd0 : sr;
  assign complete = Din_en && (cnt_eff == 2'(BITS_PER_DIGIT-1));
  assign nibble   = {Din, sr_eff};
  assign good     = complete && (nibble <= BCD_MAX);
  assign bad      = complete && (nibble >  BCD_MAX);
  assign pop      = Digit_valid && Digit_ready;

  always_comb begin
    sr_nxt = sr_eff;
    if (Din_en) begin
      case (cnt_eff)
        2'd0:    sr_nxt[0] = Din;
        2'd1:    sr_nxt[1] = Din;
        2'd2:    sr_nxt[2] = Din;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      bit_cnt   <= '0;
      sr        <= '0;
      Bad_digit <= 1'b0;
      Ovf       <= 1'b0;
    end else begin
      bit_cnt   <= Din_en ? cnt_eff + 2'd1 : cnt_eff;
      sr        <= sr_nxt;
      Bad_digit <= bad;
      if (good && full && !pop) Ovf <= 1'b1;
    end
  end

  bcd_digit_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (good),
    .din   (nibble),
    .pop   (pop),
    .dout  (Digit),
    .full  (full),
    .empty (empty),
    .count (Count)
  );

  assign Digit_valid = !empty;
endmodule
